fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch and cycle sequencer that sits directly upstream of the combinational control decoder. It fetches one 8-bit instruction per instruction slot from instruction memory over a req/ack handshake and holds it in the instruction register. It generates the `cycle`/`ncycle` phase for two-cycle instructions and owns the program counter and the carry flag. Its outputs drive the decoder's `inst`, `cycle`, `ncycle` and `carry` inputs, and it consumes the decoder's `J` and `WC` back.

## Interface
- `ADDR_W`, 16, program counter / instruction address width
- `RESET_PC`, 0, PC value after reset

- `clk`  in  1  sole clock, rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address (= PC)
- `imem_ack`  in  1  memory has valid `imem_data` this cycle
- `imem_data`  in  8  fetched instruction byte
- `stall`  in  1  hold current execute cycle
- `J`  in  1  jump taken (from decoder)
- `jump_addr`  in  ADDR_W  jump target
- `WC`  in  1  write carry (from decoder)
- `carry_in`  in  1  ALU carry out
- `inst`  out  8  instruction register
- `cycle`, `ncycle`  out  1 each  execute phase and its exact complement
- `ex`  out  1  an execute cycle is in progress; downstream side effects are qualified by it
- `carry`  out  1  carry flag
- `pc`  out  ADDR_W  program counter

## Operation
- States:
  - FETCH: `imem_req`=1, `ex`=0.
  - EXEC0: `cycle`=0, `ex`=1.
  - EXEC1: `cycle`=1, `ex`=1.
- FETCH:
  - On `imem_ack`=1: `inst`←`imem_data`, `pc`←`pc`+1, go to EXEC0.
  - Otherwise stay in FETCH.
- EXEC0, `stall`=0: if `inst[7]`=1, go to EXEC1; else go to FETCH.
- EXEC1, `stall`=0: go to FETCH. If `J`=1, `pc`←`jump_addr`.
- `stall`=1 in EXEC0 or EXEC1:
  - State, `pc` and `carry` hold.
  - `J` and `WC` are ignored that cycle.
- `stall` has no effect in FETCH.
- Carry: in EXEC0 or EXEC1 with `stall`=0 and `WC`=1, `carry`←`carry_in`.
- `J` asserted in EXEC0 is ignored. The decoder only raises `J` with `cycle`=1.
- `J` and `WC` in the same EXEC1 cycle: both take effect.
- `imem_ack` outside FETCH is ignored. `imem_data` is only sampled on an accepted ack.
- PC arithmetic is modulo 2^ADDR_W: all-ones + 1 → 0. `jump_addr` is loaded unmodified.

## Timing
- Reset values:
  - state FETCH, `inst`=0x00, `cycle`=0, `ncycle`=1, `carry`=0, `pc`=RESET_PC, `ex`=0.
  - `imem_req` is forced 0 while `nrst`=0. It is 1 from the first cycle after release.
- `imem_addr` is combinational from the `pc` register. It is stable for the whole FETCH wait.
- `cycle`, `ncycle` and `ex` are decoded from registered state only, so they are glitch-free with respect to inputs.
- Minimum latency with a zero-wait ack:
  - One-cycle instruction: 2 clocks (FETCH, EXEC0).
  - `inst[7]`=1 instruction: 3 clocks (FETCH, EXEC0, EXEC1).
- Each wait cycle of `imem_ack`=0 adds exactly one FETCH clock.
- Reset asserted mid-operation returns all registers to their reset values immediately. Any pending fetch is abandoned, and an ack arriving during reset is dropped.

## Structure
- Shared package `nandy_pkg`:
  - state encoding constants `SEQ_FETCH`=2'b00, `SEQ_EXEC0`=2'b01, `SEQ_EXEC1`=2'b10.
  - `TWO_CYCLE_BIT`=7.
- One sub-module, `pc_reg`: ADDR_W register with async reset to RESET_PC. Inputs: increment enable, load enable, load value. Load has priority over increment.
- `fetch_sequencer` contains the state register, instruction register, carry flop and output decode.

## Test plan
- Reset, then ack at once with `imem_data`=0x12:
  - `imem_addr`=0x0000 on the first fetch.
  - `inst`=0x12, then one EXEC0 cycle, then FETCH at addr 0x0001.
- `imem_data`=0x85 (`inst[7]`=1), zero-wait ack: `ex`=1 for two clocks, with `cycle`=0 then 1 and `ncycle` its exact complement.
- `imem_data`=0xE0, `J`=1 and `jump_addr`=0x4000 in EXEC1: the next `imem_addr` is 0x4000.
- `WC`=1 and `carry_in`=1 together with `J`=1 in EXEC1: `carry`=1 and the PC jump both apply. A further `WC`=1 with `stall`=1 leaves `carry` unchanged.
- `pc`=0xFFFF with an ack: `pc` wraps to 0x0000. Holding `imem_ack`=0 for 3 cycles keeps `imem_req`=1 and `imem_addr` constant.
- `nrst` asserted in EXEC1 and during a pending fetch: outputs go to their reset values immediately, `imem_req`=0, and the ack during reset is ignored.

Source files
------------

// File: rtl/nandy_pkg.sv
// Shared definitions for the nandy fetch/sequence front end.
// Holds the sequencer state encoding and the instruction-format constants.
package nandy_pkg;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'b00,
        SEQ_EXEC0 = 2'b01,
        SEQ_EXEC1 = 2'b10
    } seq_state_t;

    // Opcode bit that marks an instruction needing a second execute cycle.
    localparam int TWO_CYCLE_BIT = 7;

    function automatic logic is_two_cycle(input logic [7:0] op);
        return op[TWO_CYCLE_BIT];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// pc_reg: program counter register with async active-low reset to RESET_PC.
// Ports: clk, nrst, inc (pc+1), load (pc<-load_val, wins over inc), pc out.
module pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    // Increment wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches one instruction byte per slot over req/ack, holds it
// in the instruction register and sequences the one/two-cycle execute phase.
// Ports: clk/nrst; imem_req/addr/ack/data fetch bus; stall; J/jump_addr and
// WC/carry_in from the decoder/ALU; inst, cycle, ncycle, ex, carry, pc out.
module fetch_sequencer
    import nandy_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              nrst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    input  logic              stall,
    input  logic              J,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              WC,
    input  logic              carry_in,
    output logic [7:0]        inst,
    output logic              cycle,
    output logic              ncycle,
    output logic              ex,
    output logic              carry,
    output logic [ADDR_W-1:0] pc
);

    seq_state_t state;

    logic in_fetch;
    logic in_exec0;
    logic in_exec1;
    logic accept;
    logic advance;
    logic jump_take;

    assign in_fetch  = (state == SEQ_FETCH);
    assign in_exec0  = (state == SEQ_EXEC0);
    assign in_exec1  = (state == SEQ_EXEC1);

    // Ack only counts while a fetch is outstanding.
    assign accept    = in_fetch && imem_ack;

    // An execute cycle completes only when not stalled.
    assign advance   = (in_exec0 || in_exec1) && !stall;

    // Jumps are only honoured in the second execute cycle.
    assign jump_take = in_exec1 && !stall && J;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .nrst     (nrst),
        .inc      (accept),
        .load     (jump_take),
        .load_val (jump_addr),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= SEQ_FETCH;
            inst  <= 8'h00;
            carry <= 1'b0;
        end else begin
            unique case (state)
                SEQ_FETCH: begin
                    if (imem_ack) begin
                        inst  <= imem_data;
                        state <= SEQ_EXEC0;
                    end
                end
                SEQ_EXEC0: begin
                    if (!stall) begin
                        state <= is_two_cycle(inst) ? SEQ_EXEC1
                                                    : SEQ_FETCH;
                    end
                end
                SEQ_EXEC1: begin
                    if (!stall) begin
                        state <= SEQ_FETCH;
                    end
                end
                default: state <= SEQ_FETCH;
            endcase

            if (advance && WC) begin
                carry <= carry_in;
            end
        end
    end

    // Phase outputs decode from the state register only, so they never
    // glitch on input changes. The request is gated by reset so nothing is
    // requested while the block is held in reset.
    assign imem_req  = in_fetch && nrst;
    assign imem_addr = pc;
    assign ex        = in_exec0 || in_exec1;
    assign cycle     = in_exec1;
    assign ncycle    = !in_exec1;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer.
// Steps through fetch, execute, jump, carry, stall, wrap and reset cases.
module tb_fetch_sequencer;

    logic        clk;
    logic        nrst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_data;
    logic        stall;
    logic        J;
    logic [15:0] jump_addr;
    logic        WC;
    logic        carry_in;
    logic [7:0]  inst;
    logic        cycle;
    logic        ncycle;
    logic        ex;
    logic        carry;
    logic [15:0] pc;

    int passed;
    int total;

    fetch_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .stall     (stall),
        .J         (J),
        .jump_addr (jump_addr),
        .WC        (WC),
        .carry_in  (carry_in),
        .inst      (inst),
        .cycle     (cycle),
        .ncycle    (ncycle),
        .ex        (ex),
        .carry     (carry),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks of the full reset state of every output.
    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'h0);
        chk({tag, "_pc"},    32'(pc),       32'h0);
        chk({tag, "_inst"},  32'(inst),     32'h0);
        chk({tag, "_cyc"},   32'(cycle),    32'h0);
        chk({tag, "_ncyc"},  32'(ncycle),   32'h1);
        chk({tag, "_ex"},    32'(ex),       32'h0);
        chk({tag, "_carry"}, 32'(carry),    32'h0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        nrst      = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        stall     = 1'b0;
        J         = 1'b0;
        jump_addr = 16'h0000;
        WC        = 1'b0;
        carry_in  = 1'b0;

        tick();
        tick();
        chk_reset("rst");

        // Release and fetch 0x12 with zero-wait ack.
        nrst = 1'b1;
        #1;
        chk("f0_req",  32'(imem_req),  32'h1);
        chk("f0_addr", 32'(imem_addr), 32'h0000);
        imem_ack  = 1'b1;
        imem_data = 8'h12;
        tick();
        chk("x12_inst", 32'(inst),     32'h12);
        chk("x12_ex",   32'(ex),       32'h1);
        chk("x12_cyc",  32'(cycle),    32'h0);
        chk("x12_req",  32'(imem_req), 32'h0);
        chk("x12_pc",   32'(pc),       32'h0001);
        imem_ack = 1'b0;
        tick();
        chk("f1_ex",   32'(ex),        32'h0);
        chk("f1_req",  32'(imem_req),  32'h1);
        chk("f1_addr", 32'(imem_addr), 32'h0001);

        // Two-cycle instruction 0x85.
        imem_ack  = 1'b1;
        imem_data = 8'h85;
        tick();
        imem_ack = 1'b0;
        chk("x85a_ex",   32'(ex),     32'h1);
        chk("x85a_cyc",  32'(cycle),  32'h0);
        chk("x85a_ncyc", 32'(ncycle), 32'h1);
        tick();
        chk("x85b_ex",   32'(ex),     32'h1);
        chk("x85b_cyc",  32'(cycle),  32'h1);
        chk("x85b_ncyc", 32'(ncycle), 32'h0);
        tick();
        chk("f2_ex",   32'(ex),        32'h0);
        chk("f2_addr", 32'(imem_addr), 32'h0002);

        // 0xE0: stalled EXEC0 ignores WC/J, J in EXEC0 ignored,
        // then J + WC together in EXEC1.
        imem_ack  = 1'b1;
        imem_data = 8'hE0;
        tick();
        imem_ack  = 1'b0;
        chk("xe0_pc", 32'(pc), 32'h0003);
        stall     = 1'b1;
        WC        = 1'b1;
        carry_in  = 1'b1;
        J         = 1'b1;
        jump_addr = 16'h1234;
        tick();
        chk("st0_cyc",   32'(cycle), 32'h0);
        chk("st0_ex",    32'(ex),    32'h1);
        chk("st0_carry", 32'(carry), 32'h0);
        chk("st0_pc",    32'(pc),    32'h0003);
        stall = 1'b0;
        WC    = 1'b0;
        tick();
        chk("j0_cyc", 32'(cycle), 32'h1);
        chk("j0_pc",  32'(pc),    32'h0003);
        J         = 1'b1;
        jump_addr = 16'h4000;
        WC        = 1'b1;
        carry_in  = 1'b1;
        tick();
        J  = 1'b0;
        WC = 1'b0;
        chk("j1_ex",    32'(ex),        32'h0);
        chk("j1_addr",  32'(imem_addr), 32'h4000);
        chk("j1_carry", 32'(carry),     32'h1);

        // 0x80: stalled EXEC1 holds state, pc and carry.
        imem_ack  = 1'b1;
        imem_data = 8'h80;
        tick();
        imem_ack = 1'b0;
        chk("x80_pc", 32'(pc), 32'h4001);
        tick();
        chk("x80_cyc", 32'(cycle), 32'h1);
        stall     = 1'b1;
        WC        = 1'b1;
        carry_in  = 1'b0;
        J         = 1'b1;
        jump_addr = 16'hFFFF;
        tick();
        chk("st1_cyc",   32'(cycle), 32'h1);
        chk("st1_carry", 32'(carry), 32'h1);
        chk("st1_pc",    32'(pc),    32'h4001);
        stall = 1'b0;
        WC    = 1'b0;
        tick();
        J = 1'b0;
        chk("j2_addr",  32'(imem_addr), 32'hFFFF);
        chk("j2_carry", 32'(carry),     32'h1);

        // Wait states in FETCH, stall has no effect there.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wt_req",  32'(imem_req),  32'h1);
            chk("wt_addr", 32'(imem_addr), 32'hFFFF);
            chk("wt_ex",   32'(ex),        32'h0);
        end
        stall     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 8'h01;
        tick();
        chk("wrap_pc",   32'(pc),   32'h0000);
        chk("wrap_inst", 32'(inst), 32'h01);

        // Ack outside FETCH is dropped.
        imem_data = 8'h99;
        tick();
        imem_ack = 1'b0;
        chk("ign_inst", 32'(inst),      32'h01);
        chk("ign_pc",   32'(pc),        32'h0000);
        chk("ign_ex",   32'(ex),        32'h0);

        // Reset asserted in EXEC1.
        imem_ack  = 1'b1;
        imem_data = 8'h85;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("pre_cyc", 32'(cycle), 32'h1);
        #2;
        nrst = 1'b0;
        #1;
        chk_reset("rx1");
        tick();
        nrst = 1'b1;

        // Reset during a pending fetch with ack held high.
        imem_ack  = 1'b1;
        imem_data = 8'h12;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("pf_addr", 32'(imem_addr), 32'h0001);
        nrst      = 1'b0;
        #1;
        chk_reset("rpf");
        imem_ack  = 1'b1;
        imem_data = 8'hAA;
        tick();
        chk_reset("rack");
        imem_ack = 1'b0;
        nrst     = 1'b1;
        tick();
        chk("post_ex",   32'(ex),        32'h0);
        chk("post_req",  32'(imem_req),  32'h1);
        chk("post_addr", 32'(imem_addr), 32'h0000);
        chk("post_inst", 32'(inst),      32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
